sdram_frame_reader: RTL and testbench
=====================================

SDRAM_FRAME_READER -- requirements
Module: sdram_frame_reader

Interface
REQ-001 The block SHALL have parameter FRAME_BASE, default 25'h0, giving the word address of pixel 0.
REQ-002 The block SHALL have parameter FRAME_WORDS, default 307200, giving the number of 16-bit words per frame (range 1..2^25).
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 32, giving the pixel FIFO depth (power of 2, 4..256).
REQ-004 The block SHALL have parameter MAX_PENDING, default 8, giving the maximum number of outstanding reads (1..FIFO_DEPTH).
REQ-005 The block SHALL have one clock and a synchronous, active-high reset, with ports as follows:
clk_clk  in  1  sole clock
reset_reset  in  1  synchronous active-high reset
start  in  1  one-cycle pulse that begins a frame
busy  out  1  high from start acceptance to completion
done  out  1  one-cycle pulse when the last word has returned
avm_address  out  25  word address to the SDRAM bridge
avm_byteenable_n  out  2  constant 2'b00
avm_chipselect  out  1  equals the read request
avm_writedata  out  16  constant 0
avm_read_n  out  1  active-low read request
avm_write_n  out  1  constant 1
avm_readdata  in  16  returned word
avm_readdatavalid  in  1  returned-word strobe
avm_waitrequest  in  1  bridge stall
pix_data  out  16  FIFO head word
pix_valid  out  1  FIFO not empty
pix_ready  in  1  downstream accepts pix_data

Function
REQ-006 The state machine SHALL have states IDLE, READ and DRAIN.
REQ-007 IDLE: start=1 SHALL load the address with FRAME_BASE and the issue count with 0, and move to READ; busy SHALL go high in the next cycle.
REQ-008 start SHALL be ignored while busy=1.
REQ-009 READ: the block SHALL assert a request (avm_read_n=0, avm_chipselect=1) only when pending+fifo_count < FIFO_DEPTH and pending < MAX_PENDING.
REQ-010 A request SHALL be accepted when the request is asserted and avm_waitrequest=0; while avm_waitrequest=1, the address and request SHALL be held stable.
REQ-011 On acceptance, the address SHALL increment by 1 and the issue count SHALL increment by 1; the address SHALL wrap modulo 2^25.
REQ-012 Acceptance of request FRAME_WORDS-1 SHALL move the state machine to DRAIN, and no request SHALL be asserted in the following cycle.
REQ-013 The pending counter SHALL increment on acceptance and decrement on avm_readdatavalid; when both occur in the same cycle, it SHALL stay unchanged.
REQ-014 Each avm_readdatavalid word SHALL be written to the FIFO in return order; a word arriving in IDLE SHALL be discarded.
REQ-015 DRAIN: when pending reaches 0, the block SHALL pulse done for one cycle, deassert busy and return to IDLE (in the same cycle as the last readdatavalid if it takes pending to 0).
REQ-016 The FIFO SHALL pop when pix_valid=1 and pix_ready=1; pix_data SHALL show the head word with zero-cycle read latency.
REQ-017 A push and a pop in the same cycle SHALL leave fifo_count unchanged, including when the FIFO is full.
REQ-018 By construction (REQ-009), the FIFO SHALL never overflow.
REQ-019 pix_valid SHALL be 0 when the FIFO is empty.
REQ-020 The FIFO SHALL be retained across done, so the consumer may drain it in IDLE.

Reset
REQ-021 On reset, the block SHALL return to state IDLE with avm_read_n=1, avm_chipselect=0, avm_address=FRAME_BASE, busy=0, done=0, pix_valid=0, pending=0 and the FIFO empty.
REQ-022 A reset during READ or DRAIN SHALL abandon the frame, and returns for reads in flight SHALL be discarded per REQ-014.

Configuration
REQ-023 With FRAME_READER_LOOP_EN defined, completion SHALL pulse done, reload FRAME_BASE and re-enter READ with busy held 1 (continuous scan-out); stop is by reset only.
REQ-024 Without FRAME_READER_LOOP_EN, the block SHALL perform single-frame operation per REQ-015.

Verification
REQ-025 Bench: FRAME_WORDS=4, waitrequest=0, 2-cycle read latency, pix_ready=1 -> addresses 0,1,2,3; pix_data equals the memory words in order; done pulses once; busy is high for the whole frame.
REQ-026 Bench: waitrequest high for 3 cycles on the 2nd request -> address 1 is held 3 cycles; exactly 4 acceptances occur.
REQ-027 Bench: FIFO_DEPTH=4, pix_ready=0, FRAME_WORDS=10 -> requests stop after 4 issued; fifo_count=4; raising pix_ready resumes the frame and no word is lost.
REQ-028 Bench: readdatavalid coincident with acceptance while pending=3 -> pending stays 3.
REQ-029 Bench: reset mid-READ with 2 reads pending, then 2 stray readdatavalid words -> the FIFO stays empty and pix_valid=0.
REQ-030 Bench: with FRAME_READER_LOOP_EN defined and FRAME_WORDS=3 -> address sequence 0,1,2,0,1,2; done pulses after each frame; busy never drops.

Source files
------------

// File: rtl/sdram_frame_reader_if.sv
// rtl/sdram_frame_reader_if.sv - SDRAM bridge read port and pixel stream bundle for sdram_frame_reader
interface sdram_frame_reader_if;
  logic [24:0] avm_address;
  logic [1:0]  avm_byteenable_n;
  logic        avm_chipselect;
  logic [15:0] avm_writedata;
  logic        avm_read_n;
  logic        avm_write_n;
  logic [15:0] avm_readdata;
  logic        avm_readdatavalid;
  logic        avm_waitrequest;
  logic [15:0] pix_data;
  logic        pix_valid;
  logic        pix_ready;

  // master: the frame reader (drives bridge requests, sources pixels)
  modport master (
    output avm_address, avm_byteenable_n, avm_chipselect, avm_writedata,
    output avm_read_n, avm_write_n,
    input  avm_readdata, avm_readdatavalid, avm_waitrequest,
    output pix_data, pix_valid,
    input  pix_ready
  );

  // slave: the SDRAM bridge plus pixel consumer side
  modport slave (
    input  avm_address, avm_byteenable_n, avm_chipselect, avm_writedata,
    input  avm_read_n, avm_write_n,
    output avm_readdata, avm_readdatavalid, avm_waitrequest,
    input  pix_data, pix_valid,
    output pix_ready
  );
endinterface

// File: rtl/sdram_frame_reader.sv
// rtl/sdram_frame_reader.sv - streams one frame of 16-bit words from SDRAM into a pixel FIFO (FRAME_READER_LOOP_EN: continuous scan-out)
module sdram_frame_reader #(
  parameter logic [24:0] FRAME_BASE  = 25'h0,
  parameter int          FRAME_WORDS = 307200,
  parameter int          FIFO_DEPTH  = 32,
  parameter int          MAX_PENDING = 8
) (
  input  logic clk_clk,
  input  logic reset_reset,
  input  logic start,
  output logic busy,
  output logic done,
  sdram_frame_reader_if.master bus
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(MAX_PENDING + 1);
  localparam logic [25:0]   LAST_IDX = 26'(FRAME_WORDS - 1);
  localparam logic [9:0]    DEPTH_W  = 10'(FIFO_DEPTH);
  localparam logic [PW-1:0] MAXP     = PW'(MAX_PENDING);
  localparam logic [CW-1:0] FULL     = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t        state_q, state_d;
  logic [24:0]   addr_q;
  logic [25:0]   issue_q;
  logic [PW-1:0] pending, pending_d;
  logic [CW-1:0] fifo_count;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [15:0]   mem [FIFO_DEPTH];

  logic [9:0] occupancy;
  logic       req, accept, ret, push, pop, load_base;

  // Request only when every outstanding read already has a reserved FIFO slot
  always_comb begin
    occupancy = 10'(pending) + 10'(fifo_count);
    req       = (state_q == READ) && (occupancy < DEPTH_W) && (pending < MAXP);
    accept    = req && !bus.avm_waitrequest;
    ret       = bus.avm_readdatavalid && (state_q != IDLE) && (pending != '0);
    pop       = bus.pix_valid && bus.pix_ready;
    push      = ret && ((fifo_count != FULL) || pop);
  end

  // Outstanding-read count: +1 on acceptance, -1 on return, unchanged when both
  always_comb begin
    pending_d = pending;
    if (accept && !ret)
      pending_d = pending + PW'(1);
    else if (!accept && ret)
      pending_d = pending - PW'(1);
  end

  // State register
  always_ff @(posedge clk_clk) begin
    if (reset_reset)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  // Next state, done pulse and base reload decision
  always_comb begin
    state_d   = state_q;
    load_base = 1'b0;
    done      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = READ;
          load_base = 1'b1;
        end
      end
      READ: begin
        if (accept && (issue_q == LAST_IDX))
          state_d = DRAIN;
      end
      DRAIN: begin
        if (pending_d == '0) begin
          done = 1'b1;
`ifdef FRAME_READER_LOOP_EN
          state_d   = READ;
          load_base = 1'b1;
`else
          state_d   = IDLE;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Address and issue counter; address wraps naturally at 2^25
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      addr_q  <= FRAME_BASE;
      issue_q <= '0;
    end else if (load_base) begin
      addr_q  <= FRAME_BASE;
      issue_q <= '0;
    end else if (accept) begin
      addr_q  <= addr_q + 25'd1;
      issue_q <= issue_q + 26'd1;
    end
  end

  // Pending counter register
  always_ff @(posedge clk_clk) begin
    if (reset_reset)
      pending <= '0;
    else
      pending <= pending_d;
  end

  // FIFO pointers and occupancy; push+pop together leaves the count alone
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)
        fifo_count <= fifo_count + CW'(1);
      else if (!push && pop)
        fifo_count <= fifo_count - CW'(1);
    end
  end

  // FIFO storage, written in return order
  always_ff @(posedge clk_clk) begin
    if (push)
      mem[wr_ptr] <= bus.avm_readdata;
  end

  // Bridge and pixel outputs
  always_comb begin
    busy                 = (state_q != IDLE);
    bus.avm_address      = addr_q;
    bus.avm_byteenable_n = 2'b00;
    bus.avm_chipselect   = req;
    bus.avm_writedata    = 16'h0000;
    bus.avm_read_n       = !req;
    bus.avm_write_n      = 1'b1;
    bus.pix_data         = mem[rd_ptr];
    bus.pix_valid        = (fifo_count != '0);
  end

endmodule

// File: tb/tb_sdram_frame_reader.sv
// tb/tb_sdram_frame_reader.sv - scoreboard bench for sdram_frame_reader
module tb_sdram_frame_reader;
`ifdef FRAME_READER_LOOP_EN
  localparam int FW_A = 3;
`else
  localparam int FW_A = 4;
`endif
  localparam int FW_B = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic busy_a, busy_b, done_a, done_b, start_a, start_b;
  sdram_frame_reader_if bus_a();
  sdram_frame_reader_if bus_b();

  sdram_frame_reader #(.FRAME_BASE(25'h0), .FRAME_WORDS(FW_A), .FIFO_DEPTH(32), .MAX_PENDING(8)) dut_a (
    .clk_clk(clk), .reset_reset(rst), .start(start_a), .busy(busy_a), .done(done_a), .bus(bus_a));
  sdram_frame_reader #(.FRAME_BASE(25'h0), .FRAME_WORDS(FW_B), .FIFO_DEPTH(4), .MAX_PENDING(4)) dut_b (
    .clk_clk(clk), .reset_reset(rst), .start(start_b), .busy(busy_b), .done(done_b), .bus(bus_b));

  logic [24:0] addr_o [2];
  logic [15:0] pixd_o [2];
  logic readn_o [2], cs_o [2], pixv_o [2], busy_o [2], done_o [2];
  logic wr_i [2], rdv_i [2], rdy_i [2], start_i [2];
  logic [15:0] rdata_i [2];

  assign addr_o[0] = bus_a.avm_address;     assign addr_o[1] = bus_b.avm_address;
  assign readn_o[0] = bus_a.avm_read_n;     assign readn_o[1] = bus_b.avm_read_n;
  assign cs_o[0] = bus_a.avm_chipselect;    assign cs_o[1] = bus_b.avm_chipselect;
  assign pixv_o[0] = bus_a.pix_valid;       assign pixv_o[1] = bus_b.pix_valid;
  assign pixd_o[0] = bus_a.pix_data;        assign pixd_o[1] = bus_b.pix_data;
  assign busy_o[0] = busy_a;                assign busy_o[1] = busy_b;
  assign done_o[0] = done_a;                assign done_o[1] = done_b;
  assign start_a = start_i[0];              assign start_b = start_i[1];
  assign bus_a.avm_waitrequest = wr_i[0];   assign bus_b.avm_waitrequest = wr_i[1];
  assign bus_a.avm_readdatavalid = rdv_i[0]; assign bus_b.avm_readdatavalid = rdv_i[1];
  assign bus_a.avm_readdata = rdata_i[0];   assign bus_b.avm_readdata = rdata_i[1];
  assign bus_a.pix_ready = rdy_i[0];        assign bus_b.pix_ready = rdy_i[1];

  int total = 0, bad = 0, cyc = 0;
  int fw [2], lat [2], issued [2], mpend [2], accepts [2], pops [2], done_cnt [2];
  int stall_idx [2], stall_left [2], addr1_stall [2], strays [2], coincide [2];
  bit in_frame [2], exp_busy [2], hold_chk [2];
  bit ctl_rst, ctl_start [2], ctl_rdy [2];
  logic sv [2][8];
  logic [15:0] sd [2][8];
  logic [15:0] q0 [$];
  logic [15:0] q1 [$];
  int addr_log [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [15:0] mem_word(int d, logic [24:0] a);
    logic [31:0] v;
    v = ({7'd0, a} * 32'd40503) ^ (32'h5A5A + 32'(d) * 32'h1F0F);
    return v[15:0];
  endfunction

  function automatic int pend_of(int d);
    return (d == 0) ? int'(dut_a.pending) : int'(dut_b.pending);
  endfunction
  function automatic int cnt_of(int d);
    return (d == 0) ? int'(dut_a.fifo_count) : int'(dut_b.fifo_count);
  endfunction
  function automatic int qsize(int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction

  task automatic qpush(int d, logic [15:0] v);
    if (d == 0) q0.push_back(v); else q1.push_back(v);
  endtask
  task automatic qpop(int d, output logic [15:0] v);
    if (d == 0) v = q0.pop_front(); else v = q1.pop_front();
  endtask

  task automatic observe(int d);
    bit acc, rv, pop, exp_done, was_busy;
    int pend_next, slot;
    logic [15:0] ev;
    if (rst) return;
    was_busy = exp_busy[d];
    acc  = !readn_o[d] && !wr_i[d] && in_frame[d] && (issued[d] < fw[d]);
    rv   = rdv_i[d] && in_frame[d] && (mpend[d] > 0);
    pop  = pixv_o[d] && rdy_i[d];
    if (rdv_i[d] && !in_frame[d]) strays[d]++;
    check("busy", busy_o[d], exp_busy[d]);
    check("pending", pend_of(d), mpend[d]);
    check("fifo_count", cnt_of(d), qsize(d));
    check("pix_valid", pixv_o[d], qsize(d) > 0);
    check("chipselect", cs_o[d], !readn_o[d]);
    if (hold_chk[d]) begin
      check("pend_hold", pend_of(d), 3);
      hold_chk[d] = 0;
    end
    if (!in_frame[d] || issued[d] >= fw[d]) check("no_request", readn_o[d], 1);
    else if (!readn_o[d]) check("address", addr_o[d], issued[d]);
    if (!readn_o[d] && wr_i[d] && issued[d] == 1) addr1_stall[d]++;
    if (pop) begin
      if (qsize(d) == 0) check("pix_underrun", pixv_o[d], 0);
      else begin
        qpop(d, ev);
        check("pix_data", pixd_o[d], ev);
        pops[d]++;
      end
    end
    if (rv) qpush(d, rdata_i[d]);
    if (acc && rv && mpend[d] == 3) begin
      coincide[d]++;
      hold_chk[d] = 1;
    end
    exp_done  = in_frame[d] && (issued[d] == fw[d]);
    pend_next = mpend[d] + int'(acc) - int'(rv);
    exp_done  = exp_done && (pend_next == 0);
    if (acc) begin
      slot = (cyc + lat[d]) % 8;
      sv[d][slot] = 1'b1;
      sd[d][slot] = mem_word(d, addr_o[d]);
      if (d == 0) addr_log.push_back(int'(addr_o[d]));
      issued[d]++;
      accepts[d]++;
    end
    check("done", done_o[d], exp_done);
    mpend[d] = pend_next;
    if (exp_done) begin
      done_cnt[d]++;
`ifdef FRAME_READER_LOOP_EN
      issued[d] = 0;
`else
      in_frame[d] = 0;
      exp_busy[d] = 0;
`endif
    end
    if (start_i[d] && !was_busy) begin
      in_frame[d] = 1;
      exp_busy[d] = 1;
      issued[d]   = 0;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    rst = ctl_rst;
    for (int d = 0; d < 2; d++) begin
      start_i[d] = ctl_start[d];
      rdy_i[d]   = ctl_rdy[d];
      rdv_i[d]   = sv[d][cyc % 8];
      rdata_i[d] = sd[d][cyc % 8];
      sv[d][cyc % 8] = 1'b0;
      wr_i[d] = 1'b0;
      if (!readn_o[d] && stall_left[d] > 0 && issued[d] == stall_idx[d]) begin
        wr_i[d] = 1'b1;
        stall_left[d]--;
      end
    end
    #1;
    for (int d = 0; d < 2; d++) observe(d);
  endtask

  task automatic do_reset();
    ctl_rst = 1;
    tick();
    ctl_rst = 0;
    for (int d = 0; d < 2; d++) begin
      in_frame[d] = 0; exp_busy[d] = 0; mpend[d] = 0; issued[d] = 0; hold_chk[d] = 0;
    end
    q0.delete();
    q1.delete();
  endtask

  task automatic clear_stats(int d);
    accepts[d] = 0; pops[d] = 0; done_cnt[d] = 0; addr1_stall[d] = 0;
    strays[d] = 0; coincide[d] = 0; stall_left[d] = 0; stall_idx[d] = -1;
  endtask

  task automatic pulse_start(int d);
    ctl_start[d] = 1;
    tick();
    ctl_start[d] = 0;
  endtask

  task automatic run_until_done(int d, int n, int bound);
    int k = 0;
    while (done_cnt[d] < n && k < bound) begin
      tick();
      k++;
    end
    check("done_timeout", done_cnt[d], n);
  endtask

  initial begin
    fw[0] = FW_A; fw[1] = FW_B;
    for (int d = 0; d < 2; d++) begin
      lat[d] = 2; issued[d] = 0; mpend[d] = 0; in_frame[d] = 0; exp_busy[d] = 0;
      hold_chk[d] = 0; ctl_start[d] = 0; ctl_rdy[d] = 1;
      start_i[d] = 0; rdy_i[d] = 1; wr_i[d] = 0; rdv_i[d] = 0; rdata_i[d] = '0;
      for (int s = 0; s < 8; s++) begin sv[d][s] = 1'b0; sd[d][s] = '0; end
      clear_stats(d);
    end
    ctl_rst = 1;

    do_reset();
    tick();
    check("rst_address", bus_a.avm_address, 0);
    check("rst_read_n", bus_a.avm_read_n, 1);
    check("rst_chipselect", bus_a.avm_chipselect, 0);
    check("rst_busy", busy_a, 0);
    check("rst_done", done_a, 0);
    check("rst_pix_valid", bus_a.pix_valid, 0);
    check("const_byteenable_n", bus_a.avm_byteenable_n, 0);
    check("const_writedata", bus_a.avm_writedata, 0);
    check("const_write_n", bus_a.avm_write_n, 1);

`ifdef FRAME_READER_LOOP_EN
    clear_stats(0);
    addr_log.delete();
    pulse_start(0);
    run_until_done(0, 2, 200);
    check("loop_busy_held", busy_a, 1);
    check("loop_accepts", accepts[0] >= 6, 1);
    begin
      int exp_seq [6] = '{0, 1, 2, 0, 1, 2};
      for (int i = 0; i < 6; i++)
        check("loop_addr_seq", (i < addr_log.size()) ? addr_log[i] : -1, exp_seq[i]);
    end
    do_reset();
    repeat (6) tick();
`else
    // plain frame
    clear_stats(0);
    addr_log.delete();
    pulse_start(0);
    run_until_done(0, 1, 100);
    repeat (4) tick();
    check("f1_accepts", accepts[0], 4);
    check("f1_done_count", done_cnt[0], 1);
    check("f1_pops", pops[0], 4);
    check("f1_busy_after", busy_a, 0);
    for (int i = 0; i < 4; i++)
      check("f1_addr_seq", (i < addr_log.size()) ? addr_log[i] : -1, i);

    // start ignored while busy, plus waitrequest stall on the second request
    clear_stats(0);
    stall_idx[0] = 1; stall_left[0] = 3;
    pulse_start(0);
    pulse_start(0);
    run_until_done(0, 1, 100);
    repeat (4) tick();
    check("stall_addr1_cycles", addr1_stall[0], 3);
    check("stall_accepts", accepts[0], 4);
    check("stall_pops", pops[0], 4);
    check("stall_done_count", done_cnt[0], 1);

    // 3-cycle latency: acceptance coincides with a return at pending=3
    clear_stats(0);
    lat[0] = 3;
    pulse_start(0);
    run_until_done(0, 1, 100);
    repeat (4) tick();
    check("coincide_seen", coincide[0] > 0, 1);
    check("lat3_pops", pops[0], 4);

    // FIFO back-pressure on the shallow instance
    clear_stats(1);
    lat[1] = 2; ctl_rdy[1] = 0;
    pulse_start(1);
    repeat (30) tick();
    check("bp_accepts", accepts[1], 4);
    check("bp_fifo_count", cnt_of(1), 4);
    check("bp_pix_valid", bus_b.pix_valid, 1);
    check("bp_busy", busy_b, 1);
    ctl_rdy[1] = 1;
    run_until_done(1, 1, 300);
    repeat (6) tick();
    check("bp_total_accepts", accepts[1], 10);
    check("bp_pops", pops[1], 10);
    check("bp_fifo_empty", cnt_of(1), 0);

    // reset mid-frame with two reads in flight
    clear_stats(0);
    lat[0] = 4; ctl_rdy[0] = 0;
    pulse_start(0);
    begin
      int k = 0;
      while (mpend[0] < 2 && k < 20) begin tick(); k++; end
    end
    check("rst_mid_pending", mpend[0], 2);
    do_reset();
    repeat (8) tick();
    check("stray_words", strays[0], 2);
    check("stray_fifo_count", cnt_of(0), 0);
    check("stray_pix_valid", bus_a.pix_valid, 0);
    check("stray_busy", busy_a, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
